// File: rtl/uart_xcvr.sv
// ---------------------------------------------------------------------------
// uart_xcvr
//   Parametrised full-duplex UART transceiver.
//   - Configurable data width (5..9), parity (none/odd/even) and 1 or 2 stop
//     bits.
//   - The transmit side takes one word per ready/valid handshake.
//   - The receive side reports each word with a one-cycle strobe, together
//     with parity and framing error flags.
//
// Parameters
//   CLK_FREQ   system clock frequency in Hz
//   UART_BPS   line rate; one bit lasts CLK_FREQ/UART_BPS clocks (>= 4)
//   DATA_BITS  data bits per frame (5..9)
//   PARITY     0 = none, 1 = odd, 2 = even
//   STOP_BITS  1 or 2
//
// Ports
//   clk            system clock
//   resetn         asynchronous active-low reset
//   tx_valid       transmit request, tx_data valid
//   tx_data        word to send
//   tx_ready       transmitter idle, a word is accepted on tx_valid
//   uart_txd       serial output, idles high
//   uart_rxd       serial input, asynchronous to clk
//   rx_valid       one-cycle strobe, rx_data and error flags valid
//   rx_data        received word (first bit on the line is the LSB)
//   rx_parity_err  parity mismatch, always 0 without parity
//   rx_frame_err   first stop bit sampled low
// ---------------------------------------------------------------------------
module uart_xcvr #(
  parameter int CLK_FREQ  = 50000000,
  parameter int UART_BPS  = 115200,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 tx_valid,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_ready,
  output logic                 uart_txd,
  input  logic                 uart_rxd,
  output logic                 rx_valid,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err
);

  localparam int BPS_CNT   = CLK_FREQ / UART_BPS;
  localparam int STOP_CLKS = STOP_BITS * BPS_CNT;
  // One counter width serves both the per-bit count and the (possibly
  // double-length) stop period.
  localparam int CNT_W     = $clog2(STOP_CLKS);
  localparam int BIT_W     = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BPS_CNT - 1);
  localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_CLKS - 1);
  localparam logic [CNT_W-1:0] MID_CNT   = CNT_W'(BPS_CNT / 2);
  localparam logic [BIT_W-1:0] IDX_LAST  = BIT_W'(DATA_BITS - 1);

  localparam logic HAS_PAR = (PARITY != 0);
  // XOR of the data gives even parity; odd parity is its complement.
  localparam logic ODD_PAR = (PARITY == 1);

  // -------------------------------------------------------------------------
  // Transmitter
  // -------------------------------------------------------------------------
  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_t;

  tx_state_t            tx_state;
  logic [CNT_W-1:0]     tx_cnt;
  logic [BIT_W-1:0]     tx_bit;
  logic [DATA_BITS-1:0] tx_shift;
  logic                 tx_par;

  // uart_txd is registered: every state transition loads the level of the
  // bit that starts on the next clock, so each bit lasts exactly BPS_CNT
  // clocks on the pin.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      tx_par   <= 1'b0;
      tx_ready <= 1'b1;
      uart_txd <= 1'b1;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          if (tx_valid && tx_ready) begin
            tx_shift <= tx_data;
            tx_par   <= (^tx_data) ^ ODD_PAR;
            tx_ready <= 1'b0;
            uart_txd <= 1'b0;
            tx_cnt   <= '0;
            tx_state <= TX_START;
          end
        end

        TX_START: begin
          if (tx_cnt == BIT_LAST) begin
            tx_cnt   <= '0;
            tx_bit   <= '0;
            uart_txd <= tx_shift[0];
            tx_shift <= tx_shift >> 1;
            tx_state <= TX_DATA;
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end

        TX_DATA: begin
          if (tx_cnt == BIT_LAST) begin
            tx_cnt <= '0;
            if (tx_bit == IDX_LAST) begin
              if (HAS_PAR) begin
                uart_txd <= tx_par;
                tx_state <= TX_PARITY;
              end else begin
                uart_txd <= 1'b1;
                tx_state <= TX_STOP;
              end
            end else begin
              tx_bit   <= tx_bit + 1'b1;
              uart_txd <= tx_shift[0];
              tx_shift <= tx_shift >> 1;
            end
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end

        TX_PARITY: begin
          if (tx_cnt == BIT_LAST) begin
            tx_cnt   <= '0;
            uart_txd <= 1'b1;
            tx_state <= TX_STOP;
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end

        TX_STOP: begin
          // The whole stop period is one count so two stop bits need no
          // extra state.
          if (tx_cnt == STOP_LAST) begin
            tx_cnt   <= '0;
            tx_ready <= 1'b1;
            tx_state <= TX_IDLE;
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end

        default: begin
          tx_state <= TX_IDLE;
          tx_ready <= 1'b1;
          uart_txd <= 1'b1;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Receiver
  // -------------------------------------------------------------------------
  // Two-stage synchroniser. It resets to the idle (high) level so that a
  // release from reset does not look like a start bit.
  logic [1:0] rxd_sync;
  logic       rxd_s;
  logic       rxd_prev;

  assign rxd_s = rxd_sync[1];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rxd_sync <= 2'b11;
      rxd_prev <= 1'b1;
    end else begin
      rxd_sync <= {rxd_sync[0], uart_rxd};
      rxd_prev <= rxd_sync[1];
    end
  end

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP,
    RX_WAIT_HIGH
  } rx_state_t;

  rx_state_t            rx_state;
  logic [CNT_W-1:0]     rx_cnt;
  logic [BIT_W-1:0]     rx_bit;
  logic [DATA_BITS-1:0] rx_shift;
  logic                 rx_par;

  // The counter is cleared at every sample point. START samples at
  // mid-bit; each later state samples BPS_CNT clocks after the previous
  // sample, so every sample stays near the middle of its bit.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rx_state      <= RX_IDLE;
      rx_cnt        <= '0;
      rx_bit        <= '0;
      rx_shift      <= '0;
      rx_par        <= 1'b0;
      rx_valid      <= 1'b0;
      rx_data       <= '0;
      rx_parity_err <= 1'b0;
      rx_frame_err  <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          if (rxd_prev && !rxd_s) begin
            rx_cnt   <= '0;
            rx_state <= RX_START;
          end
        end

        RX_START: begin
          if (rx_cnt == MID_CNT) begin
            rx_cnt <= '0;
            rx_bit <= '0;
            // A line that is back high at mid start bit was a glitch.
            rx_state <= rxd_s ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end

        RX_DATA: begin
          if (rx_cnt == BIT_LAST) begin
            rx_cnt   <= '0;
            rx_shift <= {rxd_s, rx_shift[DATA_BITS-1:1]};
            if (rx_bit == IDX_LAST) begin
              rx_state <= HAS_PAR ? RX_PARITY : RX_STOP;
            end else begin
              rx_bit <= rx_bit + 1'b1;
            end
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end

        RX_PARITY: begin
          if (rx_cnt == BIT_LAST) begin
            rx_cnt   <= '0;
            rx_par   <= rxd_s;
            rx_state <= RX_STOP;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end

        RX_STOP: begin
          if (rx_cnt == BIT_LAST) begin
            rx_cnt        <= '0;
            rx_valid      <= 1'b1;
            rx_data       <= rx_shift;
            rx_parity_err <= HAS_PAR & ((^rx_shift) ^ rx_par ^ ODD_PAR);
            rx_frame_err  <= ~rxd_s;
            // A low stop bit may be a break; do not re-arm on a falling
            // edge until the line has returned high.
            rx_state      <= rxd_s ? RX_IDLE : RX_WAIT_HIGH;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end

        RX_WAIT_HIGH: begin
          if (rxd_s) begin
            rx_state <= RX_IDLE;
          end
        end

        default: begin
          rx_state <= RX_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_xcvr.sv
// ---------------------------------------------------------------------------
// tb_uart_xcvr
//   Two transceivers are instantiated:
//     inst 0 : 8 data bits, no parity, 1 stop bit
//     inst 1 : 7 data bits, even parity, 2 stop bits
//   With CLK_FREQ=1600000 and UART_BPS=100000, each bit lasts 16 clocks.
//   Each receive line is either looped from its own uart_txd or driven by
//   the bench.
//   The reference model builds each frame as a list of line levels from
//   the framing rules. It expands that list into a per-clock expected txd
//   and tx_ready trace, and keeps received words in queues.
// ---------------------------------------------------------------------------
module tb_uart_xcvr;

  localparam int CLK_FREQ = 1600000;
  localparam int UART_BPS = 100000;
  localparam int BPS      = CLK_FREQ / UART_BPS;

  logic clk    = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  // Shared transmit stimulus, steered to one instance by sel.
  int         sel = 0;
  logic       tv  = 1'b0;
  logic [8:0] td  = '0;

  logic       drv_a  = 1'b1, drv_b  = 1'b1;
  logic       loop_a = 1'b1, loop_b = 1'b1;

  logic       tx_ready_a, txd_a, rx_valid_a, pe_a, fe_a;
  logic [7:0] rx_data_a;
  logic       tx_ready_b, txd_b, rx_valid_b, pe_b, fe_b;
  logic [6:0] rx_data_b;

  logic tv_a, tv_b, rxd_a, rxd_b, mon_txd, mon_rdy;
  assign tv_a    = tv && (sel == 0);
  assign tv_b    = tv && (sel == 1);
  assign rxd_a   = loop_a ? txd_a : drv_a;
  assign rxd_b   = loop_b ? txd_b : drv_b;
  assign mon_txd = (sel == 1) ? txd_b : txd_a;
  assign mon_rdy = (sel == 1) ? tx_ready_b : tx_ready_a;

  uart_xcvr #(.CLK_FREQ(CLK_FREQ), .UART_BPS(UART_BPS), .DATA_BITS(8),
              .PARITY(0), .STOP_BITS(1)) u_a (
    .clk(clk), .resetn(resetn),
    .tx_valid(tv_a), .tx_data(td[7:0]), .tx_ready(tx_ready_a), .uart_txd(txd_a),
    .uart_rxd(rxd_a), .rx_valid(rx_valid_a), .rx_data(rx_data_a),
    .rx_parity_err(pe_a), .rx_frame_err(fe_a));

  uart_xcvr #(.CLK_FREQ(CLK_FREQ), .UART_BPS(UART_BPS), .DATA_BITS(7),
              .PARITY(2), .STOP_BITS(2)) u_b (
    .clk(clk), .resetn(resetn),
    .tx_valid(tv_b), .tx_data(td[6:0]), .tx_ready(tx_ready_b), .uart_txd(txd_b),
    .uart_rxd(rxd_b), .rx_valid(rx_valid_b), .rx_data(rx_data_b),
    .rx_parity_err(pe_b), .rx_frame_err(fe_b));

  // ---------------- reference model helpers ----------------
  function automatic int nbits(input int s); return (s == 1) ? 7 : 8; endfunction
  function automatic int npar(input int s);  return (s == 1) ? 2 : 0; endfunction
  function automatic int nstop(input int s); return (s == 1) ? 2 : 1; endfunction
  function automatic logic [8:0] dmask(input int s);
    return (s == 1) ? 9'h07F : 9'h0FF;
  endfunction

  typedef bit bitq_t[$];

  // Line levels of one frame, one entry per bit time.
  function automatic bitq_t frame_bits(input int s, input logic [8:0] d);
    bitq_t q;
    int ones;
    ones = 0;
    q.push_back(1'b0);
    for (int i = 0; i < nbits(s); i++) begin
      q.push_back(d[i]);
      if (d[i]) ones++;
    end
    if (npar(s) == 1) q.push_back(bit'((ones % 2) == 0));
    else if (npar(s) == 2) q.push_back(bit'((ones % 2) == 1));
    for (int i = 0; i < nstop(s); i++) q.push_back(1'b1);
    return q;
  endfunction

  typedef struct {
    logic [8:0] d;
    logic       pe;
    logic       fe;
  } rx_t;
  rx_t rxq_a[$];
  rx_t rxq_b[$];

  always @(negedge clk) begin
    rx_t e;
    if (rx_valid_a === 1'b1) begin
      e.d = {1'b0, rx_data_a}; e.pe = pe_a; e.fe = fe_a;
      rxq_a.push_back(e);
    end
    if (rx_valid_b === 1'b1) begin
      e.d = {2'b00, rx_data_b}; e.pe = pe_b; e.fe = fe_b;
      rxq_b.push_back(e);
    end
  end

  // ---------------- checking ----------------
  int total  = 0;
  int passed = 0;
  int failed = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_drv(input int s, input logic v);
    if (s == 1) drv_b = v; else drv_a = v;
  endtask

  task automatic set_loop(input int s, input logic v);
    if (s == 1) loop_b = v; else loop_a = v;
  endtask

  task automatic rx_expect(input int s, input int n, input string tag);
    chk({tag, " rx_valid count"}, (s == 1) ? rxq_b.size() : rxq_a.size(), n);
  endtask

  task automatic rx_pop(input int s, input logic [8:0] d, input logic pe,
                        input logic fe, input string tag);
    rx_t e;
    int n;
    n = (s == 1) ? rxq_b.size() : rxq_a.size();
    if (n == 0) begin
      chk({tag, " rx word present"}, 0, 1);
    end else begin
      e = (s == 1) ? rxq_b.pop_front() : rxq_a.pop_front();
      chk({tag, " rx {data,perr,ferr}"}, {e.d, e.pe, e.fe}, {d, pe, fe});
    end
  endtask

  task automatic rx_flush();
    rxq_a.delete();
    rxq_b.delete();
  endtask

  task automatic wait_ready(input string tag);
    int t;
    t = 0;
    while (mon_rdy !== 1'b1 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 2000) chk({tag, " tx_ready timeout"}, 0, 1);
  endtask

  // Sends d0 (and with two=1, holds tx_valid so d1 follows back to back).
  // Every clock of txd and tx_ready is compared against the model trace.
  // In single mode a tx_valid pulse with other data is issued mid-frame;
  // it must be ignored.
  task automatic tx_check(input int s, input logic [8:0] d0, input logic [8:0] d1,
                          input bit two, input string tag);
    bitq_t f0, f1;
    bit    et[$];
    bit    er[$];
    int    l0, bad, first_bad;
    f0 = frame_bits(s, d0);
    f1 = frame_bits(s, d1);
    foreach (f0[k]) repeat (BPS) begin et.push_back(f0[k]); er.push_back(1'b0); end
    l0 = et.size();
    et.push_back(1'b1); er.push_back(1'b1);
    if (two) begin
      foreach (f1[k]) repeat (BPS) begin et.push_back(f1[k]); er.push_back(1'b0); end
      et.push_back(1'b1); er.push_back(1'b1);
    end
    sel = s;
    wait_ready(tag);
    tv = 1'b1;
    td = d0;
    bad = 0;
    first_bad = -1;
    for (int i = 0; i < et.size(); i++) begin
      @(negedge clk);
      if (mon_txd !== et[i] || mon_rdy !== er[i]) begin
        bad++;
        if (first_bad < 0) first_bad = i;
      end
      if (!two && i == 0) begin tv = 1'b0; td = ~d0; end
      if (!two && i == 5 * BPS) tv = 1'b1;
      if (!two && i == 5 * BPS + 1) tv = 1'b0;
      if (two && i == 0) td = d1;
      if (two && i == l0 + 1) tv = 1'b0;
    end
    tv = 1'b0;
    chk($sformatf("%s txd/tx_ready trace bad cycles (first %0d)", tag, first_bad), bad, 0);
  endtask

  // Bench-driven frame; flip inverts the parity bit, stop_val sets the
  // first stop bit.
  task automatic drive_rx(input int s, input logic [8:0] d, input bit flip, input bit stop_val);
    bitq_t f;
    int    idx;
    f = frame_bits(s, d);
    idx = 1 + nbits(s);
    if (npar(s) != 0) begin
      if (flip) f[idx] = ~f[idx];
      idx++;
    end
    f[idx] = stop_val;
    set_loop(s, 1'b0);
    foreach (f[k]) begin
      set_drv(s, f[k]);
      repeat (BPS) @(negedge clk);
    end
  endtask

  task automatic rx_release(input int s);
    set_drv(s, 1'b1);
    repeat (2 * BPS) @(negedge clk);
    set_loop(s, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run exceeded time limit (passed %0d of %0d so far)", passed, total);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int         s;
    logic [8:0] d;
    bit         flip, stp;

    // ---- reset state ----
    repeat (3) @(negedge clk);
    chk("reset txd_a", txd_a, 1);
    chk("reset tx_ready_a", tx_ready_a, 1);
    chk("reset rx_valid_a", rx_valid_a, 0);
    chk("reset rx_data_a", rx_data_a, 0);
    chk("reset errs_a", {pe_a, fe_a}, 0);
    chk("reset txd_b", txd_b, 1);
    chk("reset tx_ready_b", tx_ready_b, 1);
    chk("reset rx_valid_b", rx_valid_b, 0);
    chk("reset rx_data_b", rx_data_b, 0);
    chk("reset errs_b", {pe_b, fe_b}, 0);
    resetn = 1'b1;
    repeat (4) @(negedge clk);

    // ---- 8N1 0xA5 loopback ----
    tx_check(0, 9'h0A5, 9'h000, 1'b0, "a5 8N1");
    repeat (4) @(negedge clk);
    rx_expect(0, 1, "a5 8N1");
    rx_pop(0, 9'h0A5, 1'b0, 1'b0, "a5 8N1");
    rx_flush();

    // ---- random loopback words on both instances ----
    for (int n = 0; n < 8; n++) begin
      s = int'($urandom_range(0, 1));
      d = 9'($urandom) & dmask(s);
      tx_check(s, d, 9'h000, 1'b0, $sformatf("rand tx %0d inst%0d", n, s));
      repeat (4) @(negedge clk);
      rx_expect(s, 1, $sformatf("rand tx %0d", n));
      rx_pop(s, d, 1'b0, 1'b0, $sformatf("rand tx %0d", n));
      rx_flush();
    end

    // ---- two stop bits, tx_valid held: 0x55 then 0x2A back to back ----
    tx_check(1, 9'h055, 9'h02A, 1'b1, "b2b 7E2");
    repeat (4) @(negedge clk);
    rx_expect(1, 2, "b2b 7E2");
    rx_pop(1, 9'h055, 1'b0, 1'b0, "b2b first");
    rx_pop(1, 9'h02A, 1'b0, 1'b0, "b2b second");
    rx_flush();

    // ---- even parity, 7 bits, 0x07: parity bit 1 on the line ----
    tx_check(1, 9'h007, 9'h000, 1'b0, "par tx 0x07");
    repeat (4) @(negedge clk);
    rx_flush();
    drive_rx(1, 9'h007, 1'b1, 1'b1);
    rx_release(1);
    rx_expect(1, 1, "par flip 0x07");
    rx_pop(1, 9'h007, 1'b1, 1'b0, "par flip 0x07");
    rx_flush();

    // ---- random bench-driven frames with optional parity/stop faults ----
    for (int n = 0; n < 8; n++) begin
      s    = int'($urandom_range(0, 1));
      d    = 9'($urandom) & dmask(s);
      flip = bit'($urandom_range(0, 1));
      stp  = bit'($urandom_range(0, 1));
      drive_rx(s, d, flip, stp);
      rx_release(s);
      rx_expect(s, 1, $sformatf("rand rx %0d inst%0d", n, s));
      rx_pop(s, d, flip && (npar(s) != 0), !stp, $sformatf("rand rx %0d", n));
      rx_flush();
    end

    // ---- framing error followed by a long break ----
    drive_rx(0, 9'h0E1, 1'b0, 1'b0);
    drv_a = 1'b0;
    repeat (40 * BPS) @(negedge clk);
    rx_expect(0, 1, "break");
    rx_pop(0, 9'h0E1, 1'b0, 1'b1, "break");
    rx_flush();
    drv_a = 1'b1;
    repeat (3 * BPS) @(negedge clk);
    rx_expect(0, 0, "break released");
    drive_rx(0, 9'h096, 1'b0, 1'b1);
    rx_release(0);
    rx_expect(0, 1, "after break");
    rx_pop(0, 9'h096, 1'b0, 1'b0, "after break");
    rx_flush();

    // ---- 4-clock glitch must not produce a word ----
    loop_a = 1'b0;
    drv_a  = 1'b0;
    repeat (4) @(negedge clk);
    drv_a  = 1'b1;
    repeat (3 * BPS) @(negedge clk);
    rx_expect(0, 0, "glitch");
    drive_rx(0, 9'h03C, 1'b0, 1'b1);
    rx_release(0);
    rx_expect(0, 1, "post glitch 0x3C");
    rx_pop(0, 9'h03C, 1'b0, 1'b0, "post glitch 0x3C");
    rx_flush();

    // ---- reset in the middle of a looped frame ----
    sel = 0;
    wait_ready("reset mid");
    tv = 1'b1;
    td = 9'h05A;
    @(negedge clk);
    tv = 1'b0;
    repeat (4 * BPS) @(negedge clk);
    resetn = 1'b0;
    #1;
    chk("reset mid txd_a", txd_a, 1);
    chk("reset mid tx_ready_a", tx_ready_a, 1);
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    repeat (12 * BPS) @(negedge clk);
    rx_expect(0, 0, "reset mid dropped");
    rx_flush();
    tx_check(0, 9'h0C3, 9'h000, 1'b0, "after reset");
    repeat (4) @(negedge clk);
    rx_expect(0, 1, "after reset");
    rx_pop(0, 9'h0C3, 1'b0, 1'b0, "after reset");
    rx_flush();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
